// File: rtl/dc_ipu_addr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dc_ipu_addr_pkg
// Brief    : Shared types, limits and width helper for the IPU address lanes.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
package dc_ipu_addr_pkg;

  typedef enum logic {
    ADDR_MODE_EDGE   = 1'b0,
    ADDR_MODE_CENTER = 1'b1
  } addr_mode_t;

  localparam int LANES_MAX      = 4;
  localparam int MUL_STAGES_MAX = 4;

  // Exact width of tex_size * {x+i, mode}, with x+i carried one bit wide.
  function automatic int addr_result_width(input int tex_w, input int img_w);
    return tex_w + img_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dc_ipu_addr_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : dc_ipu_addr_stage_reg
// Brief    : One valid/data pipeline stage with bubble-squeezing advance.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module dc_ipu_addr_stage_reg
  import dc_ipu_addr_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  clr,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  dn_adv,
  output logic                  adv,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // An empty stage can always take a beat, so ready ripples back combinationally.
  assign adv   = !r_valid || dn_adv;
  assign valid = r_valid;
  assign data  = r_data;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (clr) begin
        r_valid <= 1'b0;
      end else if (adv) begin
        r_valid <= up_valid;
        r_data  <= up_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dc_ipu_addr_compute_lanes.sv
`default_nettype none
// ============================================================================
// Module   : dc_ipu_addr_compute_lanes
// Brief    : Per-lane tex_size*(2(x+i)+mode) with in-range mask, pipelined.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module dc_ipu_addr_compute_lanes
  import dc_ipu_addr_pkg::*;
#(
  parameter int TEX_SIZE_WIDTH = 12,
  parameter int IMG_SIZE_WIDTH = 12,
  parameter int LANES          = 2,
  parameter int MUL_STAGES     = 2,
  parameter int RESULT_WIDTH   = 26
) (
  input  logic                            clk,
  input  logic                            nreset,
  input  logic                            clr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IMG_SIZE_WIDTH-1:0]       in_img_size,
  input  logic [TEX_SIZE_WIDTH-1:0]       in_tex_size,
  input  logic [IMG_SIZE_WIDTH-1:0]       in_x,
  input  logic                            in_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IMG_SIZE_WIDTH-1:0]       out_img_size,
  output logic [IMG_SIZE_WIDTH-1:0]       out_x,
  output logic [LANES-1:0]                out_lane_mask,
  output logic [LANES*RESULT_WIDTH-1:0]   out_result
);

  localparam int c_prod_w = addr_result_width(TEX_SIZE_WIDTH, IMG_SIZE_WIDTH);
  localparam int c_s0_w   = TEX_SIZE_WIDTH + 2*IMG_SIZE_WIDTH + 1;
  localparam int c_beat_w = 2*IMG_SIZE_WIDTH + LANES + LANES*RESULT_WIDTH;

  logic [MUL_STAGES:0]       w_adv;
  logic [MUL_STAGES-1:0]     w_valid;
  logic [c_beat_w-1:0]       w_pipe_data [MUL_STAGES];
  logic [c_s0_w-1:0]         w_s0_data;

  logic [TEX_SIZE_WIDTH-1:0]     w_s0_tex;
  logic [IMG_SIZE_WIDTH-1:0]     w_s0_img;
  logic [IMG_SIZE_WIDTH-1:0]     w_s0_x;
  addr_mode_t                    w_s0_mode;
  logic [LANES-1:0]              w_mask;
  logic [LANES*RESULT_WIDTH-1:0] w_result;

  assign w_adv[MUL_STAGES] = out_ready;
  assign in_ready          = w_adv[0];

  dc_ipu_addr_stage_reg #(
    .DATA_WIDTH (c_s0_w)
  ) u_stage0 (
    .clk      (clk),
    .nreset   (nreset),
    .clr      (clr),
    .up_valid (in_valid),
    .up_data  ({in_tex_size, in_img_size, in_x, in_mode}),
    .dn_adv   (w_adv[1]),
    .adv      (w_adv[0]),
    .valid    (w_valid[0]),
    .data     (w_s0_data)
  );

  assign w_s0_tex  = w_s0_data[c_s0_w-1 -: TEX_SIZE_WIDTH];
  assign w_s0_img  = w_s0_data[2*IMG_SIZE_WIDTH -: IMG_SIZE_WIDTH];
  assign w_s0_x    = w_s0_data[IMG_SIZE_WIDTH -: IMG_SIZE_WIDTH];
  assign w_s0_mode = addr_mode_t'(w_s0_data[0]);

  // Lane coordinate keeps its carry so x+i never wraps into range.
  always_comb begin : p_lane_calc
    logic [IMG_SIZE_WIDTH:0]   xi;
    logic [IMG_SIZE_WIDTH+1:0] op;
    logic [c_prod_w-1:0]       prod;
    w_mask   = '0;
    w_result = '0;
    for (int i = 0; i < LANES; i++) begin
      xi   = {1'b0, w_s0_x} + (IMG_SIZE_WIDTH+1)'(i);
      op   = {xi, (w_s0_mode == ADDR_MODE_CENTER)};
      prod = c_prod_w'(w_s0_tex) * c_prod_w'(op);
      w_result[i*RESULT_WIDTH +: RESULT_WIDTH] = RESULT_WIDTH'(prod);
      w_mask[i] = (xi < {1'b0, w_s0_img});
    end
  end

  assign w_pipe_data[0] = {w_s0_img, w_s0_x, w_mask, w_result};

  // Remaining stages only carry the finished product so synthesis can retime it.
  for (genvar gk = 1; gk < MUL_STAGES; gk++) begin : g_stage
    dc_ipu_addr_stage_reg #(
      .DATA_WIDTH (c_beat_w)
    ) u_stage (
      .clk      (clk),
      .nreset   (nreset),
      .clr      (clr),
      .up_valid (w_valid[gk-1]),
      .up_data  (w_pipe_data[gk-1]),
      .dn_adv   (w_adv[gk+1]),
      .adv      (w_adv[gk]),
      .valid    (w_valid[gk]),
      .data     (w_pipe_data[gk])
    );
  end

  assign out_valid = w_valid[MUL_STAGES-1];
  assign {out_img_size, out_x, out_lane_mask, out_result} = w_pipe_data[MUL_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_dc_ipu_addr_compute_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_ipu_addr_compute_lanes
// Brief    : Directed self-checking bench for dc_ipu_addr_compute_lanes.
// Revision : 1.0 - initial multi-lane release
// ============================================================================
module tb_dc_ipu_addr_compute_lanes;

  localparam int c_tex_w   = 12;
  localparam int c_img_w   = 12;
  localparam int c_lanes   = 2;
  localparam int c_stages  = 2;
  localparam int c_res_w   = 26;

  logic                        clk = 1'b0;
  logic                        nreset;
  logic                        clr;
  logic                        in_valid;
  logic                        in_ready;
  logic [c_img_w-1:0]          in_img_size;
  logic [c_tex_w-1:0]          in_tex_size;
  logic [c_img_w-1:0]          in_x;
  logic                        in_mode;
  logic                        out_valid;
  logic                        out_ready;
  logic [c_img_w-1:0]          out_img_size;
  logic [c_img_w-1:0]          out_x;
  logic [c_lanes-1:0]          out_lane_mask;
  logic [c_lanes*c_res_w-1:0]  out_result;

  int n_cmp = 0;
  int n_mis = 0;

  dc_ipu_addr_compute_lanes #(
    .TEX_SIZE_WIDTH (c_tex_w),
    .IMG_SIZE_WIDTH (c_img_w),
    .LANES          (c_lanes),
    .MUL_STAGES     (c_stages),
    .RESULT_WIDTH   (c_res_w)
  ) u_dut (
    .clk           (clk),
    .nreset        (nreset),
    .clr           (clr),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_img_size   (in_img_size),
    .in_tex_size   (in_tex_size),
    .in_x          (in_x),
    .in_mode       (in_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_img_size  (out_img_size),
    .out_x         (out_x),
    .out_lane_mask (out_lane_mask),
    .out_result    (out_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [c_tex_w-1:0] tex, input logic [c_img_w-1:0] img,
                       input logic [c_img_w-1:0] x, input logic m);
    in_valid    = v;
    in_tex_size = tex;
    in_img_size = img;
    in_x        = x;
    in_mode     = m;
  endtask

  // One beat into an idle pipe with out_ready=1; checked two edges later.
  task automatic send_check(input string tag, input logic [c_tex_w-1:0] tex, input logic [c_img_w-1:0] img,
                            input logic [c_img_w-1:0] x, input logic m,
                            input logic [63:0] r0, input logic [63:0] r1, input logic [1:0] mask);
    drive(1'b1, tex, img, x, m);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_r0"}, 64'(out_result[c_res_w-1:0]), r0);
    chk({tag, "_r1"}, 64'(out_result[2*c_res_w-1:c_res_w]), r1);
    chk({tag, "_mask"}, 64'(out_lane_mask), 64'(mask));
    chk({tag, "_x"}, 64'(out_x), 64'(x));
    chk({tag, "_img"}, 64'(out_img_size), 64'(img));
    tick();
  endtask

  initial begin
    int got;
    int seen;
    logic [c_img_w-1:0] got_x [8];
    logic [c_res_w-1:0] got_r0 [8];

    nreset    = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_x", 64'(out_x), 64'd0);
    chk("rst_out_mask", 64'(out_lane_mask), 64'd0);
    nreset = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    send_check("basic", 12'd640, 12'd1920, 12'd0, 1'b1, 64'd640, 64'd1920, 2'b11);
    send_check("edge", 12'd640, 12'd1920, 12'd1919, 1'b0, 64'd2456320, 64'd2457600, 2'b01);
    send_check("ovf", 12'd4095, 12'd4095, 12'd4095, 1'b1, 64'd33542145, 64'd33550335, 2'b00);
    send_check("post", 12'd3, 12'd5, 12'd4, 1'b1, 64'd27, 64'd33, 2'b01);

    // Backpressure: two beats fill the pipe, the third waits.
    out_ready = 1'b0;
    drive(1'b1, 12'd1, 12'd100, 12'd0, 1'b0);
    #1 chk("bp_rdy_a", 64'(in_ready), 64'd1);
    tick();
    drive(1'b1, 12'd1, 12'd100, 12'd2, 1'b0);
    #1 chk("bp_rdy_b", 64'(in_ready), 64'd1);
    tick();
    drive(1'b1, 12'd1, 12'd100, 12'd4, 1'b0);
    #1 chk("bp_rdy_c", 64'(in_ready), 64'd0);
    chk("bp_valid_c", 64'(out_valid), 64'd1);
    chk("bp_x_c", 64'(out_x), 64'd0);
    tick();
    #1 chk("bp_rdy_d", 64'(in_ready), 64'd0);
    chk("bp_x_d", 64'(out_x), 64'd0);
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      #1;
      if (out_valid && out_ready) begin
        got_x[got]  = out_x;
        got_r0[got] = out_result[c_res_w-1:0];
        got++;
      end
      if (in_valid && in_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    chk("bp_count", 64'(got), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_order%0d", i), 64'(got_x[i]), 64'(2*i));
      chk($sformatf("bp_res%0d", i), 64'(got_r0[i]), 64'(4*i));
    end
    repeat (2) tick();
    chk("bp_no_dup", 64'(out_valid), 64'd0);

    // Bubble squeeze: beat parked in last stage, stage 0 empty.
    drive(1'b1, 12'd1, 12'd100, 12'd10, 1'b0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("bs_valid", 64'(out_valid), 64'd1);
    drive(1'b1, 12'd1, 12'd100, 12'd12, 1'b0);
    #1 chk("bs_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1 chk("bs_full_rdy", 64'(in_ready), 64'd0);
    chk("bs_hold_x", 64'(out_x), 64'd10);
    out_ready = 1'b1;
    tick();
    chk("bs_next_x", 64'(out_x), 64'd12);
    chk("bs_next_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bs_drained", 64'(out_valid), 64'd0);

    // Flush with a simultaneous handshake.
    out_ready = 1'b0;
    drive(1'b1, 12'd1, 12'd100, 12'd20, 1'b0);
    tick();
    drive(1'b1, 12'd1, 12'd100, 12'd22, 1'b0);
    tick();
    out_ready = 1'b1;
    clr       = 1'b1;
    drive(1'b1, 12'd1, 12'd100, 12'd24, 1'b0);
    #1 chk("clr_in_ready", 64'(in_ready), 64'd1);
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("clr_no_ghost", 64'(seen), 64'd0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    drive(1'b1, 12'd7, 12'd100, 12'd30, 1'b1);
    tick();
    drive(1'b1, 12'd7, 12'd100, 12'd32, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 nreset = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_result", 64'(out_result), 64'd0);
    chk("ar_x", 64'(out_x), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    tick();
    nreset    = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("ar_no_ghost", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
